dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data/IO memory between two requesters: the pipeline's load/store port in the EX stage (cpu_*) and the UART program-loader/DMA port (ld_*).
- Round-robin arbitration, with an optional loader lock for burst programming.
- Drives a synchronous RAM with 1-cycle read latency and returns read data to the owning requester.
- Exports a stall flag that freezes the IF/EXE pipeline registers while the CPU request waits, plus a saturating stall counter for CSR readout.

Parameters:
ADDR_WIDTH, 14, word-address width (byte address bits [ADDR_WIDTH+1:2])
DATA_WIDTH, 32, data word width; byte enables are DATA_WIDTH/8 wide

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low (rst=0 resets on the rising clk edge)
cpu_req_valid  in  1  CPU access request
cpu_req_ready  out  1  CPU request accepted this cycle
cpu_addr  in  ADDR_WIDTH  CPU word address
cpu_we  in  DATA_WIDTH/8  CPU byte write enables; 0 means read
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_WIDTH  CPU read data
cpu_stall  out  1  cpu_req_valid and not cpu_req_ready
ld_req_valid  in  1  loader access request
ld_req_ready  out  1  loader request accepted
ld_lock  in  1  loader requests exclusive ownership
ld_addr  in  ADDR_WIDTH  loader word address
ld_we  in  DATA_WIDTH/8  loader byte enables; 0 means read
ld_wdata  in  DATA_WIDTH  loader write data
ld_rvalid  out  1  loader read data valid
ld_rdata  out  DATA_WIDTH  loader read data
mem_en  out  1  RAM enable
mem_we  out  DATA_WIDTH/8  RAM byte write enables
mem_addr  out  ADDR_WIDTH  RAM address
mem_din  out  DATA_WIDTH  RAM write data
mem_dout  in  DATA_WIDTH  RAM read data, valid one cycle after a read with mem_en=1
stall_cnt_clr  in  1  clears stall_cnt
stall_cnt  out  16  saturating count of cycles with cpu_stall=1

Behaviour:
- FSM states:
  - PRI_CPU: CPU wins ties.
  - PRI_LD: loader wins ties.
  - LD_LOCK: only the loader may be granted.
- Reset state is PRI_CPU.
- Grant (combinational from state and valids):
  - At most one ready is high per cycle.
  - A lone valid requester is granted in PRI_CPU and PRI_LD.
  - In LD_LOCK, cpu_req_ready=0 always.
- Transfer = valid & ready in the same cycle. In that cycle:
  - mem_en=1.
  - mem_addr, mem_we and mem_din are muxed from the winner.
  - With no transfer: mem_en=0, mem_we=0; mem_addr and mem_din hold the CPU values.
- Transitions on each clk edge:
  - CPU transfer -> PRI_LD.
  - Loader transfer with ld_lock=1 -> LD_LOCK.
  - Loader transfer with ld_lock=0 -> PRI_CPU.
  - In LD_LOCK with ld_lock=0 -> PRI_CPU, whether or not a transfer occurs. A transfer in that cycle is allowed and is still loader-only.
  - Otherwise the state holds.
- Read latency: a read transfer (we==0) in cycle N gives <port>_rvalid=1 in cycle N+1 for exactly one cycle, with <port>_rdata=mem_dout. Both rdata outputs pass mem_dout through unconditionally; only rvalid is qualified.
- Writes produce no response. Back-to-back transfers, one per cycle, are supported with no bubbles.
- Requesters hold valid, addr, we and wdata stable until ready. A dropped valid before ready is legal and cancels the request.
- stall_cnt:
  - Increments when cpu_stall=1 and stall_cnt<16'hFFFF.
  - Holds at 16'hFFFF.
  - stall_cnt_clr=1 forces 0 next cycle and takes priority over increment.
- Reset (rst=0):
  - State goes to PRI_CPU.
  - cpu_rvalid=0, ld_rvalid=0, stall_cnt=0.
  - Both readies are 0 and mem_en=0 while rst=0, since the outputs are gated by reset.
  - A read accepted in the cycle before reset assertion produces no rvalid; reset wins.
  - The first cycle after release behaves as PRI_CPU.
- Simultaneous events:
  - Both valid in PRI_CPU: CPU granted; loader waits exactly one cycle if the CPU stops requesting.
  - Continuous requests from both sides alternate grants strictly.

Test Plan:
- Reset, then CPU read of addr 0x010 with mem model returning 0xDEADBEEF -> cpu_req_ready=1 in the request cycle, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF the next cycle, ld_rvalid=0.
- Both valid continuously for 6 cycles, all reads -> grant order CPU, LD, CPU, LD, CPU, LD; cpu_stall high in cycles 2, 4, 6; stall_cnt=3.
- Loader writes 0x11223344 to addr 0x020 with ld_we=4'hF and ld_lock=1 for 4 beats while the CPU is valid -> all 4 loader beats granted consecutively, cpu_stall=1 for 4 cycles; after ld_lock=0 the CPU is granted on the next cycle.
- CPU write with cpu_we=4'b0100 and wdata 0x00AB0000 -> mem_we=4'b0100 and mem_din=0x00AB0000 in the same cycle, no cpu_rvalid.
- CPU held stalled by ld_lock for 70000 cycles -> stall_cnt saturates at 0xFFFF; stall_cnt_clr pulse -> 0 the next cycle.
- CPU read accepted, then rst=0 on the following edge -> cpu_rvalid stays 0, state returns to PRI_CPU; after release, simultaneous requests grant the CPU first.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports (CPU load/store, UART loader/DMA) and the
//   synchronous RAM port that the data-memory arbiter sits between.
//
//   Handshake rule for both requester ports:
//     A transfer happens in every cycle where <port>_req_valid and
//     <port>_req_ready are both 1.  A requester keeps addr/we/wdata stable
//     while valid is high and ready is low.  It may drop valid before ready,
//     which cancels the request.  ready may depend combinationally on valid.
//     A read transfer (we == 0) in cycle N is answered by <port>_rvalid = 1
//     in cycle N+1 for exactly one cycle.  Writes get no response.
//
//   Modports:
//     slave  - the arbiter: consumes requests and mem_dout, drives readies,
//              read responses, stall flag and the RAM control signals.
//     master - the environment: requesters plus the RAM model.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // CPU (EX stage load/store) port
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [BE_WIDTH-1:0]   cpu_we;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;

  // Loader / DMA port
  logic                  ld_req_valid;
  logic                  ld_req_ready;
  logic                  ld_lock;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [BE_WIDTH-1:0]   ld_we;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic                  ld_rvalid;
  logic [DATA_WIDTH-1:0] ld_rdata;

  // Synchronous single-port RAM, 1-cycle read latency
  logic                  mem_en;
  logic [BE_WIDTH-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  cpu_req_valid, cpu_addr, cpu_we, cpu_wdata,
    output cpu_req_ready, cpu_rvalid, cpu_rdata, cpu_stall,
    input  ld_req_valid, ld_lock, ld_addr, ld_we, ld_wdata,
    output ld_req_ready, ld_rvalid, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req_valid, cpu_addr, cpu_we, cpu_wdata,
    input  cpu_req_ready, cpu_rvalid, cpu_rdata, cpu_stall,
    output ld_req_valid, ld_lock, ld_addr, ld_we, ld_wdata,
    input  ld_req_ready, ld_rvalid, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data/IO RAM between the CPU load/store port and the
//   UART loader/DMA port.  Round-robin between the two, with a loader lock
//   that lets the loader own the RAM for a whole programming burst.
//
//   Ports:
//     clk           system clock
//     rst           synchronous active-low reset (rst=0 resets on rising clk)
//     bus           dmem_arbiter_if.slave: both requester ports + RAM port
//     stall_cnt_clr clears stall_cnt on the next edge (wins over increment)
//     stall_cnt     saturating count of cycles with cpu_stall=1 (CSR readout)
//     state_dbg     current arbitration state (00 PRI_CPU, 01 PRI_LD,
//                   10 LD_LOCK)
//
//   Arbitration states:
//     PRI_CPU  CPU wins a tie
//     PRI_LD   loader wins a tie
//     LD_LOCK  only the loader can be granted; left when ld_lock drops
//   A lone requester is always granted outside LD_LOCK, so one transfer per
//   cycle is possible with no bubbles.  Winning a transfer hands tie priority
//   to the other side, which makes continuous contention alternate strictly.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       bus,
  input  logic                stall_cnt_clr,
  output logic [15:0]         stall_cnt,
  output logic [1:0]          state_dbg
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    PRI_CPU = 2'b00,
    PRI_LD  = 2'b01,
    LD_LOCK = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;

  logic cpu_gnt;
  logic ld_gnt;

  logic [BE_WIDTH-1:0]   mux_we;
  logic [ADDR_WIDTH-1:0] mux_addr;
  logic [DATA_WIDTH-1:0] mux_din;

  logic cpu_rvalid_q;
  logic ld_rvalid_q;
  logic cpu_stall_c;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= PRI_CPU;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant and next state.  Grants already include the requester's valid, so
  // a grant is a transfer.  Everything is forced idle while rst=0 so that no
  // RAM access can start during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_gnt   = 1'b0;
    ld_gnt    = 1'b0;
    state_nxt = state;

    if (rst) begin
      case (state)
        PRI_CPU: begin
          cpu_gnt = bus.cpu_req_valid;
          ld_gnt  = bus.ld_req_valid & ~bus.cpu_req_valid;
        end
        PRI_LD: begin
          ld_gnt  = bus.ld_req_valid;
          cpu_gnt = bus.cpu_req_valid & ~bus.ld_req_valid;
        end
        LD_LOCK: begin
          ld_gnt  = bus.ld_req_valid;
        end
        default: begin
          cpu_gnt = 1'b0;
          ld_gnt  = 1'b0;
        end
      endcase

      if (cpu_gnt) begin
        state_nxt = PRI_LD;
      end else if (ld_gnt) begin
        state_nxt = bus.ld_lock ? LD_LOCK : PRI_CPU;
      end else if ((state == LD_LOCK) && !bus.ld_lock) begin
        // Lock released without a transfer in the same cycle.
        state_nxt = PRI_CPU;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM request mux.  With no transfer the address/data buses idle on the CPU
  // values; only mem_en and mem_we tell the RAM nothing is happening.
  // ---------------------------------------------------------------------------
  always_comb begin
    mux_we   = '0;
    mux_addr = bus.cpu_addr;
    mux_din  = bus.cpu_wdata;
    if (ld_gnt) begin
      mux_we   = bus.ld_we;
      mux_addr = bus.ld_addr;
      mux_din  = bus.ld_wdata;
    end else if (cpu_gnt) begin
      mux_we   = bus.cpu_we;
    end
  end

  assign bus.mem_en   = cpu_gnt | ld_gnt;
  assign bus.mem_we   = mux_we;
  assign bus.mem_addr = mux_addr;
  assign bus.mem_din  = mux_din;

  assign bus.cpu_req_ready = cpu_gnt;
  assign bus.ld_req_ready  = ld_gnt;

  assign cpu_stall_c   = bus.cpu_req_valid & ~cpu_gnt;
  assign bus.cpu_stall = cpu_stall_c;

  // ---------------------------------------------------------------------------
  // Read response tracking.  The RAM returns data one cycle after a read, so
  // remembering who issued the read is enough to steer rvalid; rdata is a
  // plain pass-through of mem_dout on both ports.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_rvalid_q <= 1'b0;
      ld_rvalid_q  <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt & (bus.cpu_we == '0);
      ld_rvalid_q  <= ld_gnt  & (bus.ld_we  == '0);
    end
  end

  // Gating with rst drops the response of a read accepted right before reset
  // is asserted: the flag is still set in the first reset cycle.
  assign bus.cpu_rvalid = cpu_rvalid_q & rst;
  assign bus.ld_rvalid  = ld_rvalid_q  & rst;
  assign bus.cpu_rdata  = bus.mem_dout;
  assign bus.ld_rdata   = bus.mem_dout;

  // ---------------------------------------------------------------------------
  // Saturating stall counter; clear wins over increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= 16'h0000;
    end else if (stall_cnt_clr) begin
      stall_cnt <= 16'h0000;
    end else if (cpu_stall_c && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed scenarios followed by randomized traffic.  A reference model
//   (tie priority flag, lock flag, word-array memory, stall counter) predicts
//   readies, RAM controls and the stall count every cycle, and pushes expected
//   read data into per-port queues; a separate monitor pops them whenever the
//   DUT raises rvalid.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        rst;
  logic        stall_cnt_clr;
  logic [15:0] stall_cnt;
  logic [1:0]  state_dbg;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (ifc),
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt),
    .state_dbg     (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Counters and comparison helper
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] init_word(int a);
    if (a == 'h10) return 32'hDEADBEEF;
    return 32'hA5000000 ^ (a * 32'h00010101);
  endfunction

  // ---------------------------------------------------------------------------
  // RAM model (environment): synchronous, 1-cycle read latency
  // ---------------------------------------------------------------------------
  logic [31:0] ram [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
    ifc.mem_dout <= '0;
    forever begin
      @(posedge clk);
      if (ifc.mem_en) begin
        if (ifc.mem_we != '0) ram[ifc.mem_addr] = merge(ram[ifc.mem_addr], ifc.mem_din, ifc.mem_we);
        else                  ifc.mem_dout <= ram[ifc.mem_addr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model + per-cycle checks
  //   ld_turn : the loader wins a tie (the last transfer went to the CPU)
  //   locked  : loader holds exclusive ownership
  // ---------------------------------------------------------------------------
  logic [31:0] cpu_exp_q[$];
  logic [31:0] ld_exp_q[$];

  initial begin
    logic [31:0] ref_mem [0:DEPTH-1];
    logic        ld_turn, locked, exp_crv, exp_lrv;
    logic [15:0] m_cnt;
    logic        cv, lv, cg, lg, stall;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    ld_turn = 1'b0; locked = 1'b0; exp_crv = 1'b0; exp_lrv = 1'b0; m_cnt = 16'h0;
    forever begin
      @(negedge clk);
      cv = ifc.cpu_req_valid;
      lv = ifc.ld_req_valid;
      cg = rst && cv && !locked && (!lv || !ld_turn);
      lg = rst && lv && (locked || !cv || ld_turn);
      stall = cv && !cg;

      chk("cpu_req_ready", 32'(ifc.cpu_req_ready), 32'(cg));
      chk("ld_req_ready",  32'(ifc.ld_req_ready),  32'(lg));
      chk("mem_en",        32'(ifc.mem_en),        32'(cg | lg));
      if (lg) begin
        chk("mem_we_ld",   32'(ifc.mem_we),   32'(ifc.ld_we));
        chk("mem_addr_ld", 32'(ifc.mem_addr), 32'(ifc.ld_addr));
        chk("mem_din_ld",  ifc.mem_din,       ifc.ld_wdata);
      end else begin
        chk("mem_we",      32'(ifc.mem_we),   32'(cg ? ifc.cpu_we : 4'h0));
        chk("mem_addr",    32'(ifc.mem_addr), 32'(ifc.cpu_addr));
        chk("mem_din",     ifc.mem_din,       ifc.cpu_wdata);
      end
      chk("cpu_stall",  32'(ifc.cpu_stall),  32'(stall));
      chk("stall_cnt",  32'(stall_cnt),      32'(m_cnt));
      chk("cpu_rvalid", 32'(ifc.cpu_rvalid), 32'(exp_crv && rst));
      chk("ld_rvalid",  32'(ifc.ld_rvalid),  32'(exp_lrv && rst));

      // advance the model to the next cycle
      if (!rst) begin
        cpu_exp_q.delete();
        ld_exp_q.delete();
      end
      exp_crv = cg && (ifc.cpu_we == 4'h0);
      exp_lrv = lg && (ifc.ld_we == 4'h0);
      if (exp_crv) cpu_exp_q.push_back(ref_mem[ifc.cpu_addr]);
      if (exp_lrv) ld_exp_q.push_back(ref_mem[ifc.ld_addr]);
      if (cg && !exp_crv) ref_mem[ifc.cpu_addr] = merge(ref_mem[ifc.cpu_addr], ifc.cpu_wdata, ifc.cpu_we);
      if (lg && !exp_lrv) ref_mem[ifc.ld_addr]  = merge(ref_mem[ifc.ld_addr],  ifc.ld_wdata,  ifc.ld_we);

      if (!rst || stall_cnt_clr) m_cnt = 16'h0;
      else if (stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;

      if (!rst) begin
        ld_turn = 1'b0; locked = 1'b0;
      end else if (cg) begin
        ld_turn = 1'b1;
      end else if (lg) begin
        ld_turn = 1'b0; locked = ifc.ld_lock;
      end else if (locked && !ifc.ld_lock) begin
        locked = 1'b0; ld_turn = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: pops an expected word whenever a port shows rvalid
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (ifc.cpu_rvalid === 1'b1) begin
      if (cpu_exp_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = cpu_exp_q.pop_front();
        chk("cpu_rdata", ifc.cpu_rdata, e);
      end
    end
    if (ifc.ld_rvalid === 1'b1) begin
      if (ld_exp_q.size() == 0) chk("ld_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = ld_exp_q.pop_front();
        chk("ld_rdata", ifc.ld_rdata, e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(logic v, logic [AW-1:0] a, logic [3:0] we, logic [31:0] d);
    ifc.cpu_req_valid = v;
    ifc.cpu_addr      = a;
    ifc.cpu_we        = we;
    ifc.cpu_wdata     = d;
  endtask

  task automatic set_ld(logic v, logic lock, logic [AW-1:0] a, logic [3:0] we, logic [31:0] d);
    ifc.ld_req_valid = v;
    ifc.ld_lock      = lock;
    ifc.ld_addr      = a;
    ifc.ld_we        = we;
    ifc.ld_wdata     = d;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [5:0] cpu_seq, ld_seq;
    int         ld_beats, stall_cycles;
    logic       c_acc, l_acc;

    rst = 1'b0;
    stall_cnt_clr = 1'b0;
    set_cpu(1'b0, '0, 4'h0, 32'h0);
    set_ld(1'b0, 1'b0, '0, 4'h0, 32'h0);

    // Reset
    repeat (3) cycle();
    @(negedge clk);
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);

    // CPU read of 0x010 right after release
    cycle();
    rst = 1'b1;
    set_cpu(1'b1, 14'h010, 4'h0, 32'h0);
    @(negedge clk);
    chk("t1_cpu_ready", 32'(ifc.cpu_req_ready), 32'd1);
    cycle();
    set_cpu(1'b0, '0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t1_cpu_rvalid", 32'(ifc.cpu_rvalid), 32'd1);
    chk("t1_cpu_rdata", ifc.cpu_rdata, 32'hDEADBEEF);
    chk("t1_ld_rvalid", 32'(ifc.ld_rvalid), 32'd0);

    // Loader read alone returns tie priority to the CPU; then clear counter
    cycle();
    set_ld(1'b1, 1'b0, 14'h011, 4'h0, 32'h0);
    cycle();
    set_ld(1'b0, 1'b0, '0, 4'h0, 32'h0);
    stall_cnt_clr = 1'b1;
    cycle();
    stall_cnt_clr = 1'b0;

    // Both requesting reads for 6 cycles: strict alternation, CPU first
    cpu_seq = '0; ld_seq = '0;
    set_cpu(1'b1, 14'h012, 4'h0, 32'h0);
    set_ld(1'b1, 1'b0, 14'h013, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_seq = {cpu_seq[4:0], ifc.cpu_req_ready};
      ld_seq  = {ld_seq[4:0], ifc.ld_req_ready};
      cycle();
      if (i == 5) begin
        set_cpu(1'b0, '0, 4'h0, 32'h0);
        set_ld(1'b0, 1'b0, '0, 4'h0, 32'h0);
      end else begin
        set_cpu(1'b1, 14'h012 + 14'(i), 4'h0, 32'h0);
        set_ld(1'b1, 1'b0, 14'h020 - 14'(i), 4'h0, 32'h0);
      end
    end
    @(negedge clk);
    chk("t2_cpu_grant_order", 32'(cpu_seq), 32'b101010);
    chk("t2_ld_grant_order",  32'(ld_seq),  32'b010101);
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd3);

    // CPU byte write (also hands tie priority to the loader)
    cycle();
    set_cpu(1'b1, 14'h030, 4'b0100, 32'h00AB0000);
    @(negedge clk);
    chk("t4_mem_en",  32'(ifc.mem_en), 32'd1);
    chk("t4_mem_we",  32'(ifc.mem_we), 32'b0100);
    chk("t4_mem_din", ifc.mem_din, 32'h00AB0000);
    cycle();
    set_cpu(1'b0, '0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t4_no_cpu_rvalid", 32'(ifc.cpu_rvalid), 32'd0);

    // Locked loader burst of 4 writes while the CPU waits
    cycle();
    ld_beats = 0; stall_cycles = 0;
    set_cpu(1'b1, 14'h020, 4'h0, 32'h0);
    set_ld(1'b1, 1'b1, 14'h020, 4'hF, 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_beats     += int'(ifc.ld_req_ready);
      stall_cycles += int'(ifc.cpu_stall);
      cycle();
      if (i == 3) set_ld(1'b0, 1'b0, '0, 4'h0, 32'h0);
      else        set_ld(1'b1, 1'b1, 14'h021 + 14'(i), 4'hF, 32'h11223344);
    end
    @(negedge clk);
    chk("t3_ld_beats", 32'(ld_beats), 32'd4);
    chk("t3_cpu_stall_cycles", 32'(stall_cycles), 32'd4);
    chk("t3_cpu_ready_unlock_cycle", 32'(ifc.cpu_req_ready), 32'd0);
    cycle();
    @(negedge clk);
    chk("t3_cpu_ready_after_unlock", 32'(ifc.cpu_req_ready), 32'd1);
    cycle();
    set_cpu(1'b0, '0, 4'h0, 32'h0);

    // Stall counter saturation under a held lock, then clear
    set_ld(1'b1, 1'b1, 14'h040, 4'h0, 32'h0);
    cycle();
    set_ld(1'b0, 1'b1, '0, 4'h0, 32'h0);
    set_cpu(1'b1, 14'h041, 4'h0, 32'h0);
    repeat (70000) cycle();
    @(negedge clk);
    chk("t5_stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);
    cycle();
    stall_cnt_clr = 1'b1;
    cycle();
    stall_cnt_clr = 1'b0;
    @(negedge clk);
    chk("t5_stall_cnt_clr", 32'(stall_cnt), 32'd0);
    cycle();
    set_ld(1'b0, 1'b0, '0, 4'h0, 32'h0);
    repeat (2) cycle();
    set_cpu(1'b0, '0, 4'h0, 32'h0);

    // Read accepted, then reset on the next edge
    cycle();
    set_cpu(1'b1, 14'h010, 4'h0, 32'h0);
    @(negedge clk);
    chk("t6_cpu_ready", 32'(ifc.cpu_req_ready), 32'd1);
    cycle();
    set_cpu(1'b0, '0, 4'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cpu_rvalid_dropped", 32'(ifc.cpu_rvalid), 32'd0);
    cycle();
    @(negedge clk);
    chk("t6_state_after_reset", 32'(state_dbg), 32'd0);
    cycle();
    rst = 1'b1;
    set_cpu(1'b1, 14'h015, 4'h0, 32'h0);
    set_ld(1'b1, 1'b0, 14'h016, 4'h0, 32'h0);
    @(negedge clk);
    chk("t6_cpu_first", 32'(ifc.cpu_req_ready), 32'd1);
    chk("t6_ld_waits", 32'(ifc.ld_req_ready), 32'd0);
    cycle();
    set_cpu(1'b0, '0, 4'h0, 32'h0);

    // Randomized traffic on a small address window
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      c_acc = ifc.cpu_req_ready;
      l_acc = ifc.ld_req_ready;
      cycle();
      if (ifc.cpu_req_valid && !c_acc) begin
        if ($urandom_range(0, 7) == 0) ifc.cpu_req_valid = 1'b0;
      end else begin
        set_cpu($urandom_range(0, 9) < 6, 14'($urandom_range(0, 63)),
                ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15)), $urandom);
      end
      if (ifc.ld_req_valid && !l_acc) begin
        if ($urandom_range(0, 7) == 0) ifc.ld_req_valid = 1'b0;
      end else begin
        set_ld($urandom_range(0, 9) < 5, ifc.ld_lock, 14'($urandom_range(0, 63)),
               ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15)), $urandom);
      end
      if ($urandom_range(0, 15) == 0) ifc.ld_lock = ~ifc.ld_lock;
      stall_cnt_clr = ($urandom_range(0, 49) == 0);
    end

    // Drain
    set_cpu(1'b0, '0, 4'h0, 32'h0);
    set_ld(1'b0, 1'b0, '0, 4'h0, 32'h0);
    stall_cnt_clr = 1'b0;
    repeat (4) cycle();
    @(negedge clk);
    #1;
    chk("cpu_exp_q_empty", 32'(cpu_exp_q.size()), 32'd0);
    chk("ld_exp_q_empty",  32'(ld_exp_q.size()),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
